// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the serial-bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD_M  = 2'd1,
      HOLD_S  = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   localparam int DEF_TIMEOUT_CYCLES = 255;
   localparam int HOLD_CNT_W         = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic [PW-1:0] idx
);

   logic [PW-1:0] j;

   // Scan from the farthest offset back toward ptr so the nearest hit wins.
   always_comb begin
      pick = '0;
      idx  = '0;
      j    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = PW'((int'(ptr) + k) % N);
         if (req[j]) begin
            pick    = '0;
            pick[j] = 1'b1;
            idx     = j;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared serial bus: slave replies first, masters round-robin.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int NUM_SLAVES     = 3,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] m_req,
   input  logic [NUM_SLAVES-1:0]  s_ready,
   output logic [NUM_MASTERS-1:0] m_grant,
   output logic [NUM_SLAVES-1:0]  s_cmd,
   output logic                   bus_util,
   output logic                   bus_busy,
   output logic                   timeout_err
);

   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   arb_state_e             state, state_nxt;
   logic [NUM_MASTERS-1:0] m_grant_q, m_grant_nxt, m_pick;
   logic [NUM_SLAVES-1:0]  s_cmd_q, s_cmd_nxt, s_pick;
   logic [MW-1:0]          rr_ptr, rr_ptr_nxt, owner_m, owner_m_nxt, m_idx, rr_after;
   logic                   owner_req, timeout_hit;

   rr_pick #(.N(NUM_MASTERS), .PW(MW)) u_m_pick (
      .req  (m_req),
      .ptr  (rr_ptr),
      .pick (m_pick),
      .idx  (m_idx)
   );

   // Lowest set bit of s_ready.
   assign s_pick    = s_ready & (~s_ready + NUM_SLAVES'(1));
   assign owner_req = (|(m_grant_q & m_req)) | (|(s_cmd_q & s_ready));
   assign rr_after  = (owner_m == MW'(NUM_MASTERS - 1)) ? '0 : owner_m + MW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         m_grant_q <= '0;
         s_cmd_q   <= '0;
         rr_ptr    <= '0;
         owner_m   <= '0;
      end else begin
         state     <= state_nxt;
         m_grant_q <= m_grant_nxt;
         s_cmd_q   <= s_cmd_nxt;
         rr_ptr    <= rr_ptr_nxt;
         owner_m   <= owner_m_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      m_grant_nxt = m_grant_q;
      s_cmd_nxt   = s_cmd_q;
      rr_ptr_nxt  = rr_ptr;
      owner_m_nxt = owner_m;
      case (state)
         IDLE: begin
            if (|s_ready) begin
               s_cmd_nxt = s_pick;
               state_nxt = HOLD_S;
            end else if (|m_req) begin
               m_grant_nxt = m_pick;
               owner_m_nxt = m_idx;
               state_nxt   = HOLD_M;
            end
         end
         HOLD_M: begin
            if (!owner_req || timeout_hit) begin
               m_grant_nxt = '0;
               rr_ptr_nxt  = rr_after;
               state_nxt   = RELEASE;
            end
         end
         HOLD_S: begin
            if (!owner_req || timeout_hit) begin
               s_cmd_nxt = '0;
               state_nxt = RELEASE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign m_grant  = m_grant_q;
   assign s_cmd    = s_cmd_q;
   assign bus_util = (state == RELEASE);
   assign bus_busy = (state == HOLD_M) || (state == HOLD_S);

`ifdef ARB_TIMEOUT_EN
   logic [HOLD_CNT_W-1:0] hold_cnt;
   logic                  to_q;

   // Counter reads 0 on the first hold cycle, so a grant lasts TIMEOUT_CYCLES cycles.
   assign timeout_hit = bus_busy && (hold_cnt == HOLD_CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         to_q     <= 1'b0;
      end else begin
         hold_cnt <= bus_busy ? hold_cnt + HOLD_CNT_W'(1) : '0;
         to_q     <= timeout_hit && owner_req;
      end
   end

   assign timeout_err = to_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter against a transaction-level ownership model.
module tb_bus_arbiter;

   localparam int NM   = 2;
   localparam int NS   = 3;
   localparam int T    = 8;
   localparam int W    = NM + NS + 3;
   localparam int SOFF = 100;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NM-1:0] m_req = '0;
   logic [NS-1:0] s_ready = '0;
   logic [NM-1:0] m_grant;
   logic [NS-1:0] s_cmd;
   logic          bus_util, bus_busy, timeout_err;

   int checks = 0;
   int passed = 0;

   // Model: who owns the bus (-1 none, master j, or SOFF+i for slave i).
   int own  = -1;
   bit gap  = 1'b0;
   int rr   = 0;
   int held = 0;
   bit to_p = 1'b0;

   bus_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .m_req       (m_req),
      .s_ready     (s_ready),
      .m_grant     (m_grant),
      .s_cmd       (s_cmd),
      .bus_util    (bus_util),
      .bus_busy    (bus_busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic r, input logic [NM-1:0] mr, input logic [NS-1:0] sr);
      bit still;
      bit expire;
      to_p = 1'b0;
      if (r) begin
         own = -1; gap = 1'b0; rr = 0; held = 0;
         return;
      end
      if (gap) begin
         gap = 1'b0;
      end else if (own < 0) begin
         if (sr != 0) begin
            for (int i = NS - 1; i >= 0; i--) if (sr[i]) own = SOFF + i;
            held = 0;
         end else if (mr != 0) begin
            for (int k = NM - 1; k >= 0; k--) if (mr[(rr + k) % NM]) own = (rr + k) % NM;
            held = 0;
         end
      end else begin
         still  = (own < SOFF) ? mr[own] : sr[own - SOFF];
         expire = TO_EN && (held == T - 1);
         if (!still || expire) begin
            if (own < SOFF) rr = (own + 1) % NM;
            to_p = still;
            own  = -1;
            gap  = 1'b1;
         end else begin
            held++;
         end
      end
   endtask

   function automatic logic [W-1:0] exp_v();
      logic [NM-1:0] g = '0;
      logic [NS-1:0] s = '0;
      if (own >= 0 && own < SOFF) g[own] = 1'b1;
      if (own >= SOFF) s[own - SOFF] = 1'b1;
      return {g, s, gap, own >= 0, to_p};
   endfunction

   function automatic logic [W-1:0] obs_v();
      return {m_grant, s_cmd, bus_util, bus_busy, timeout_err};
   endfunction

   task automatic tick(input logic r, input logic [NM-1:0] mr, input logic [NS-1:0] sr);
      rst = r; m_req = mr; s_ready = sr;
      @(posedge clk);
      model_step(r, mr, sr);
      #1;
   endtask

   task automatic quiesce();
      for (int n = 0; n < 20 && (own >= 0 || gap); n++) tick(1'b0, '0, '0);
      tick(1'b0, '0, '0);
      checks++;
      if (obs_v() !== exp_v() || own >= 0 || gap) $display("FAIL quiesce: got %b want %b", obs_v(), exp_v());
      else passed++;
   endtask

   task automatic test_reset();
      tick(1'b1, '0, '0);
      tick(1'b1, 2'b11, 3'b111);
      checks++;
      if (obs_v() !== '0) $display("FAIL reset_idle: got %b want %b", obs_v(), {W{1'b0}});
      else passed++;
      tick(1'b0, 2'b01, '0);
      tick(1'b0, 2'b01, '0);
      checks++;
      if (m_grant !== 2'b01 || obs_v() !== exp_v()) $display("FAIL reset_pregrant: got %b want %b", obs_v(), exp_v());
      else passed++;
      tick(1'b1, 2'b01, '0);
      checks++;
      if (obs_v() !== '0) $display("FAIL reset_midgrant: got %b want %b", obs_v(), {W{1'b0}});
      else passed++;
      tick(1'b0, '0, '0);
      checks++;
      if (obs_v() !== '0) $display("FAIL reset_after: got %b want %b", obs_v(), {W{1'b0}});
      else passed++;
   endtask

   task automatic test_round_robin();
      logic [NM-1:0] seq[$];
      logic [NM-1:0] prev = '0;
      logic [NM-1:0] mr;
      int utils = 0;
      for (int c = 0; c < 60 && seq.size() < 4; c++) begin
         mr = 2'b11;
         if (own >= 0 && own < SOFF && held == 4) mr[own] = 1'b0;
         tick(1'b0, mr, '0);
         checks++;
         if (obs_v() !== exp_v()) $display("FAIL rr_cycle %0d: got %b want %b", c, obs_v(), exp_v());
         else passed++;
         if (bus_util) utils++;
         if (m_grant != 0 && prev == 0) seq.push_back(m_grant);
         prev = m_grant;
      end
      checks++;
      if (seq.size() != 4 || seq[0] !== 2'b01 || seq[1] !== 2'b10 || seq[2] !== 2'b01 || seq[3] !== 2'b10)
         $display("FAIL rr_sequence: got %p want 01,10,01,10", seq);
      else passed++;
      checks++;
      if (utils != 3) $display("FAIL rr_util_pulses: got %0d want 3", utils);
      else passed++;
      quiesce();
   endtask

   task automatic test_slave_priority();
      tick(1'b0, 2'b01, 3'b100);
      checks++;
      if (s_cmd !== 3'b100 || m_grant !== '0) $display("FAIL slv_prio_first: got s_cmd=%b m_grant=%b want 100/00", s_cmd, m_grant);
      else passed++;
      for (int c = 0; c < 6; c++) begin
         tick(1'b0, 2'b01, (c < 2) ? 3'b100 : 3'b000);
         checks++;
         if (obs_v() !== exp_v()) $display("FAIL slv_prio_cycle %0d: got %b want %b", c, obs_v(), exp_v());
         else passed++;
         if (c == 2) begin
            checks++;
            if (bus_util !== 1'b1) $display("FAIL slv_prio_util: got %b want 1", bus_util);
            else passed++;
         end
         if (c == 4) begin
            checks++;
            if (m_grant !== 2'b01) $display("FAIL slv_prio_master: got %b want 01", m_grant);
            else passed++;
         end
      end
      quiesce();
   endtask

   task automatic test_lowest_slave();
      logic [NS-1:0] seq[$];
      logic [NS-1:0] prev = '0;
      for (int c = 0; c < 8; c++) begin
         tick(1'b0, '0, (c < 3) ? 3'b110 : (c < 6) ? 3'b100 : 3'b000);
         checks++;
         if (obs_v() !== exp_v()) $display("FAIL low_slv_cycle %0d: got %b want %b", c, obs_v(), exp_v());
         else passed++;
         if (s_cmd != 0 && prev == 0) seq.push_back(s_cmd);
         prev = s_cmd;
      end
      checks++;
      if (seq.size() != 2 || seq[0] !== 3'b010 || seq[1] !== 3'b100)
         $display("FAIL low_slv_sequence: got %p want 010,100", seq);
      else passed++;
      quiesce();
   endtask

   task automatic test_no_preempt();
      tick(1'b0, 2'b10, '0);
      checks++;
      if (m_grant !== 2'b10) $display("FAIL nopre_grant: got %b want 10", m_grant);
      else passed++;
      for (int c = 0; c < 4; c++) begin
         tick(1'b0, 2'b11, 3'b001);
         checks++;
         if (m_grant !== 2'b10 || s_cmd !== '0 || obs_v() !== exp_v())
            $display("FAIL nopre_hold %0d: got %b want %b", c, obs_v(), exp_v());
         else passed++;
      end
      tick(1'b0, 2'b00, 3'b001);
      tick(1'b0, 2'b00, 3'b001);
      checks++;
      if (s_cmd !== '0 || bus_busy !== 1'b0) $display("FAIL nopre_gap: got s_cmd=%b busy=%b want 000/0", s_cmd, bus_busy);
      else passed++;
      tick(1'b0, 2'b00, 3'b001);
      checks++;
      if (s_cmd !== 3'b001 || obs_v() !== exp_v()) $display("FAIL nopre_slave: got %b want %b", obs_v(), exp_v());
      else passed++;
      quiesce();
   endtask

   task automatic test_hold_limit();
      int first_to = -1;
      int pulses = 0;
      for (int c = 1; c <= 300; c++) begin
         tick(1'b0, 2'b01, '0);
         checks++;
         if (obs_v() !== exp_v()) $display("FAIL hold_cycle %0d: got %b want %b", c, obs_v(), exp_v());
         else passed++;
         if (timeout_err) begin
            pulses++;
            if (first_to < 0) first_to = c;
         end
         if (TO_EN && c == 11) begin
            checks++;
            if (m_grant !== 2'b01) $display("FAIL hold_regrant: got %b want 01", m_grant);
            else passed++;
         end
      end
      checks++;
      if (TO_EN ? (first_to != T + 1 || pulses != 30) : (pulses != 0 || m_grant !== 2'b01))
         $display("FAIL hold_timeout: got first=%0d pulses=%0d grant=%b", first_to, pulses, m_grant);
      else passed++;
      quiesce();
   endtask

   task automatic test_random();
      logic [NM-1:0] mr = '0;
      logic [NS-1:0] sr = '0;
      logic          r;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NM; i++) if ($urandom_range(0, 7) == 0) mr[i] = ~mr[i];
         for (int i = 0; i < NS; i++) if ($urandom_range(0, 9) == 0) sr[i] = ~sr[i];
         r = ($urandom_range(0, 199) == 0);
         tick(r, mr, sr);
         checks++;
         if (obs_v() !== exp_v()) $display("FAIL rand_cycle %0d: got %b want %b", c, obs_v(), exp_v());
         else passed++;
      end
      quiesce();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_slave_priority();
      test_lowest_slave();
      test_no_preempt();
      test_hold_limit();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
